mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Parametrised N-port arbiter that multiplexes cache-miss traffic (I-cache, D-cache, and later prefetcher/DMA) onto one shared cacheline port toward L2/physical memory. It replaces the fixed 2-way, select-driven mux with a registered grant FSM. The FSM latches the winning request, holds the grant until the downstream response, then returns a registered response to the winner only. It supports fixed-priority or round-robin selection.

Parameters:
NUM_PORTS, 2, number of requesters (2..8)
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 256, cacheline width
ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
req_read  in  NUM_PORTS  per-port read request, held until that port's resp
req_write  in  NUM_PORTS  per-port write request, held until that port's resp
req_addr  in  NUM_PORTS*ADDR_WIDTH  per-port address, port i at bits [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  in  NUM_PORTS*DATA_WIDTH  per-port write line
req_resp  out  NUM_PORTS  one-hot, one-cycle completion pulse to the granted port
req_rdata  out  DATA_WIDTH  read line, broadcast, valid when any req_resp bit is high
mem_read  out  1  downstream read
mem_write  out  1  downstream write
mem_addr  out  ADDR_WIDTH  downstream address
mem_wdata  out  DATA_WIDTH  downstream write line
mem_resp  in  1  downstream completion (one cycle)
mem_rdata  in  DATA_WIDTH  downstream read line, valid with mem_resp
grant_valid  out  1  high in BUSY and DONE
grant_idx  out  $clog2(NUM_PORTS)  currently granted port

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0. Latched addr, wdata and op are 0. Round-robin pointer last = NUM_PORTS-1, so port 0 is searched first. Reset during BUSY abandons the downstream transaction: mem_read and mem_write drop asynchronously, and no req_resp is issued.
- States: IDLE, BUSY, DONE.
- IDLE: pending[i] = req_read[i] | req_write[i].
  - If any bit is set, pick the winner, latch its addr, wdata and op, set grant_idx, and go to BUSY.
  - Otherwise stay in IDLE.
  - Downstream outputs are 0 in IDLE.
- Winner selection:
  - ARB_MODE 0: lowest pending index.
  - ARB_MODE 1: first pending index, searching circularly from last+1 with wrap NUM_PORTS-1 -> 0. last is updated to the winner on grant.
- Op rule: if a port asserts read and write together, the write is taken and the read is ignored. The requester keeps read high and is served again later.
- BUSY:
  - mem_addr and mem_wdata are driven from registers, not live inputs.
  - mem_read/mem_write reflect the latched op. Exactly one is high; mem_wdata = 0 on reads.
  - Requests from other ports are ignored. A change on the granted port's inputs is also ignored; the latched values hold.
  - On mem_resp: register mem_rdata into req_rdata and go to DONE. mem_read/mem_write deassert on that same edge.
- DONE, one cycle:
  - req_resp[grant_idx] = 1; all other bits 0. req_rdata holds the captured line, which is also valid for writes and is don't-care to the requester.
  - Then go to IDLE.
  - The requester deasserts on the edge at which it sees resp. IDLE therefore never re-grants a completed request.
- Latency:
  - Request in IDLE at cycle t -> mem_read/mem_write high at t+1.
  - mem_resp at cycle u -> req_resp at u+1.
  - Minimum turnaround: 3 cycles plus memory latency.
  - Back-to-back grants are separated by one IDLE cycle.
- mem_resp outside BUSY is ignored.
- Zero-wait memory (mem_resp in the first BUSY cycle) is legal.
- No starvation in ARB_MODE 1: any pending port is granted within NUM_PORTS transactions. ARB_MODE 0 may starve high indices; this is intended, with the D-cache connected to port 0.

Decomposition:
- Shared package arb_pkg:
  - arb_state_t enum {IDLE, BUSY, DONE}.
  - Constants ARB_FIXED = 0 and ARB_RR = 1.
  - arb_op_t enum {OP_READ, OP_WRITE}.
- One sub-module, arb_picker, purely combinational:
  - Inputs: pending vector, last pointer, mode.
  - Outputs: winner index and any_pending.
  - Fixed priority uses last = NUM_PORTS-1.

Test Plan:
- Reset/idle: assert rst mid-BUSY with a read to 0x0000_1000 -> mem_read=0 immediately, no req_resp, grant_valid=0. After release, a new request is granted normally.
- Single read: port 1 read 0x0000_2040; mem_resp after 5 cycles with rdata = {8{32'hDEADBEEF}} -> mem_addr=0x0000_2040 the cycle after the request, req_resp=2'b10 exactly one cycle after mem_resp, req_rdata matches.
- Single write: port 0 write 0x0000_3000 with wdata = {8{32'hA5A5A5A5}} -> mem_write=1, mem_wdata matches, mem_read=0; req_resp=2'b01 for one cycle.
- Fixed-priority collision (ARB_MODE 0, NUM_PORTS 2): both ports request in the same cycle, held -> port 0 served first, then port 1. Port 0 re-requesting continuously starves port 1, as specified.
- Round-robin (ARB_MODE 1, NUM_PORTS 4): all four ports request continuously -> grant order 0,1,2,3,0. With only ports 1 and 3 pending after port 3 is served -> 1,3,1.
- Corner cases:
  - Port asserts read and write together -> write issued first.
  - Port input address changes during BUSY -> mem_addr stays latched.
  - mem_resp pulsed in IDLE -> ignored, no req_resp.
  - Zero-wait mem_resp -> req_resp the next cycle.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the cache-miss memory arbiter.
package arb_pkg;

  // Grant FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } arb_state_t;

  // Operation latched for the granted port.
  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } arb_op_t;

  // Arbitration modes.
  localparam int ARB_FIXED = 32'sd0;
  localparam int ARB_RR    = 32'sd1;

  // A write wins when a port raises read and write together; the read is
  // left pending and gets served by a later grant.
  function automatic arb_op_t pick_op(input logic wr);
    return wr ? OP_WRITE : OP_READ;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and downstream memory bus of the arbiter. The master modport is
// the arbiter's view; the slave modport is the view of the requesters and
// memory model around it.
interface mem_arbiter_if #(
  parameter int NUM_PORTS  = 32'sd2,
  parameter int ADDR_WIDTH = 32'sd32,
  parameter int DATA_WIDTH = 32'sd256
);
  localparam int IDX_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0]            req_read;
  logic [NUM_PORTS-1:0]            req_write;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_PORTS-1:0]            req_resp;
  logic [DATA_WIDTH-1:0]           req_rdata;
  logic                            mem_read;
  logic                            mem_write;
  logic [ADDR_WIDTH-1:0]           mem_addr;
  logic [DATA_WIDTH-1:0]           mem_wdata;
  logic                            mem_resp;
  logic [DATA_WIDTH-1:0]           mem_rdata;
  logic                            grant_valid;
  logic [IDX_W-1:0]                grant_idx;

  modport master (
    input  req_read, req_write, req_addr, req_wdata, mem_resp, mem_rdata,
    output req_resp, req_rdata, mem_read, mem_write, mem_addr, mem_wdata,
           grant_valid, grant_idx
  );

  modport slave (
    output req_read, req_write, req_addr, req_wdata, mem_resp, mem_rdata,
    input  req_resp, req_rdata, mem_read, mem_write, mem_addr, mem_wdata,
           grant_valid, grant_idx
  );

endinterface

// File: rtl/arb_picker.sv
// Combinational winner selection. Searches circularly starting one past
// 'last'; fixed priority is the same search pinned to last = NUM_PORTS-1,
// which makes port 0 the first candidate every time.
module arb_picker #(
  parameter int NUM_PORTS = 32'sd2,
  localparam int IDX_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] pending,
  input  logic [IDX_W-1:0]     last,
  input  logic                 mode,
  output logic [IDX_W-1:0]     winner,
  output logic                 any_pending
);

  int unsigned      base_s;
  logic [IDX_W-1:0] cand_s;
  logic             found_s;

  // Circular first-pending search from base+1.
  always_comb begin
    base_s  = mode ? 32'(last) : 32'(NUM_PORTS - 32'sd1);
    winner  = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int unsigned k = 32'd1; k <= 32'(NUM_PORTS); k++) begin
      cand_s  = IDX_W'((base_s + k) % 32'(NUM_PORTS));
      winner  = (pending[cand_s] && !found_s) ? cand_s : winner;
      found_s = found_s | pending[cand_s];
    end
  end

  assign any_pending = |pending;

endmodule

// File: rtl/mem_arbiter.sv
// N-port arbiter funnelling cache-miss traffic onto one cacheline port.
// A grant latches the winner's op/address/data, holds it until the memory
// responds, then pulses a registered response to the winner alone.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_PORTS  = 32'sd2,
  parameter int ADDR_WIDTH = 32'sd32,
  parameter int DATA_WIDTH = 32'sd256,
  parameter int ARB_MODE   = 32'sd0
) (
  input logic           clk,
  input logic           rst,
  mem_arbiter_if.master bus
);

  localparam int   IDX_W   = $clog2(NUM_PORTS);
  localparam logic RR_MODE = (ARB_MODE == ARB_RR);

  arb_state_t            state_r, state_s;
  arb_op_t               op_r, op_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [DATA_WIDTH-1:0] wdata_r, wdata_s;
  logic [DATA_WIDTH-1:0] rdata_r, rdata_s;
  logic [IDX_W-1:0]      idx_r, idx_s;
  logic [IDX_W-1:0]      last_r, last_s;
  logic [NUM_PORTS-1:0]  resp_r, resp_s;
  logic                  read_r, read_s;
  logic                  write_r, write_s;
  logic                  grant_valid_r, grant_valid_s;
  logic [IDX_W-1:0]      winner_s;
  logic                  any_s;

  arb_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .pending     (bus.req_read | bus.req_write),
    .last        (last_r),
    .mode        (RR_MODE),
    .winner      (winner_s),
    .any_pending (any_s)
  );

  // Next-state and next-output logic of the grant FSM.
  always_comb begin
    state_s       = state_r;
    op_s          = op_r;
    addr_s        = addr_r;
    wdata_s       = wdata_r;
    rdata_s       = rdata_r;
    idx_s         = idx_r;
    last_s        = last_r;
    resp_s        = '0;
    read_s        = read_r;
    write_s       = write_r;
    grant_valid_s = grant_valid_r;
    case (state_r)
      IDLE: begin
        if (any_s) begin
          state_s       = BUSY;
          idx_s         = winner_s;
          last_s        = winner_s;
          op_s          = pick_op(bus.req_write[winner_s]);
          addr_s        = bus.req_addr[winner_s*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_s       = (op_s == OP_WRITE) ?
                          bus.req_wdata[winner_s*DATA_WIDTH +: DATA_WIDTH] : '0;
          read_s        = (op_s == OP_READ);
          write_s       = (op_s == OP_WRITE);
          grant_valid_s = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        // Downstream strobes and latched bus values drop on the response edge.
        if (bus.mem_resp) begin
          state_s = DONE;
          rdata_s = bus.mem_rdata;
          resp_s  = {{(NUM_PORTS-1){1'b0}}, 1'b1} << idx_r;
          read_s  = 1'b0;
          write_s = 1'b0;
          addr_s  = '0;
          wdata_s = '0;
          op_s    = OP_READ;
        end else begin
          state_s = BUSY;
        end
      end
      DONE: begin
        state_s       = IDLE;
        grant_valid_s = 1'b0;
      end
      default: begin
        state_s       = IDLE;
        read_s        = 1'b0;
        write_s       = 1'b0;
        grant_valid_s = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any downstream transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= IDLE;
      op_r          <= OP_READ;
      addr_r        <= '0;
      wdata_r       <= '0;
      rdata_r       <= '0;
      idx_r         <= '0;
      last_r        <= IDX_W'(NUM_PORTS - 32'sd1);
      resp_r        <= '0;
      read_r        <= 1'b0;
      write_r       <= 1'b0;
      grant_valid_r <= 1'b0;
    end else begin
      state_r       <= state_s;
      op_r          <= op_s;
      addr_r        <= addr_s;
      wdata_r       <= wdata_s;
      rdata_r       <= rdata_s;
      idx_r         <= idx_s;
      last_r        <= last_s;
      resp_r        <= resp_s;
      read_r        <= read_s;
      write_r       <= write_s;
      grant_valid_r <= grant_valid_s;
    end
  end

  assign bus.req_resp    = resp_r;
  assign bus.req_rdata   = rdata_r;
  assign bus.mem_read    = read_r;
  assign bus.mem_write   = write_r;
  assign bus.mem_addr    = addr_r;
  assign bus.mem_wdata   = wdata_r;
  assign bus.grant_valid = grant_valid_r;
  assign bus.grant_idx   = idx_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: a 2-port fixed-priority arbiter (u0) and a 4-port
// round-robin arbiter (u1) share clock and reset.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mem_arbiter_if #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(256)) b0 ();
  mem_arbiter_if #(.NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(256)) b1 ();

  mem_arbiter #(.NUM_PORTS(2), .ADDR_WIDTH(32), .DATA_WIDTH(256), .ARB_MODE(0)) u0 (
    .clk(clk), .rst(rst), .bus(b0));
  mem_arbiter #(.NUM_PORTS(4), .ADDR_WIDTH(32), .DATA_WIDTH(256), .ARB_MODE(1)) u1 (
    .clk(clk), .rst(rst), .bus(b1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    b0.req_read = '0; b0.req_write = '0; b0.req_addr = '0; b0.req_wdata = '0;
    b0.mem_resp = 1'b0; b0.mem_rdata = '0;
    b1.req_read = '0; b1.req_write = '0; b1.req_addr = '0; b1.req_wdata = '0;
    b1.mem_resp = 1'b0; b1.mem_rdata = '0;
  endtask

  // Wait for u0 to start a downstream access, answer after lat cycles,
  // and return the granted index and the response vector seen in DONE.
  task automatic serve_d0(input int lat, output logic ok, output int idx, output logic [1:0] resp);
    ok = 1'b0; idx = -1; resp = 2'b00;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (b0.mem_read || b0.mem_write) begin ok = 1'b1; break; end
    end
    if (ok) begin
      idx = int'(b0.grant_idx);
      repeat (lat) tick();
      b0.mem_resp = 1'b1;
      tick();
      b0.mem_resp = 1'b0;
      resp = b0.req_resp;
    end
  endtask

  task automatic serve_d1(input int lat, output logic ok, output int idx, output logic [3:0] resp);
    ok = 1'b0; idx = -1; resp = 4'b0000;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (b1.mem_read || b1.mem_write) begin ok = 1'b1; break; end
    end
    if (ok) begin
      idx = int'(b1.grant_idx);
      repeat (lat) tick();
      b1.mem_resp = 1'b1;
      tick();
      b1.mem_resp = 1'b0;
      resp = b1.req_resp;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick(); tick();
    vectors++;
    if ({b0.mem_read, b0.mem_write, b0.mem_addr, b0.mem_wdata, b0.req_resp, b0.req_rdata,
         b0.grant_valid, b0.grant_idx} !== '0) begin
      miscompares++; $display("FAIL reset_u0: outputs not all zero (mem_read=%0b gv=%0b)", b0.mem_read, b0.grant_valid);
    end
    vectors++;
    if ({b1.mem_read, b1.mem_write, b1.mem_addr, b1.mem_wdata, b1.req_resp, b1.req_rdata,
         b1.grant_valid, b1.grant_idx} !== '0) begin
      miscompares++; $display("FAIL reset_u1: outputs not all zero (mem_read=%0b gv=%0b)", b1.mem_read, b1.grant_valid);
    end
    rst = 1'b0;
    tick();
    // reset in the middle of a read
    b0.req_read[0] = 1'b1;
    b0.req_addr[0 +: 32] = 32'h0000_1000;
    tick();
    vectors++;
    if ({b0.mem_read, b0.mem_addr} !== {1'b1, 32'h0000_1000}) begin
      miscompares++; $display("FAIL rst_busy_pre: got rd=%0b addr=%h want rd=1 addr=00001000", b0.mem_read, b0.mem_addr);
    end
    tick();
    rst = 1'b1;
    #1;
    vectors++;
    if ({b0.mem_read, b0.grant_valid, b0.req_resp} !== 4'b0000) begin
      miscompares++; $display("FAIL rst_busy_abort: got rd=%0b gv=%0b resp=%b want 0/0/00", b0.mem_read, b0.grant_valid, b0.req_resp);
    end
    b0.req_read = '0;
    b0.mem_resp = 1'b1;
    tick();
    b0.mem_resp = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (b0.req_resp !== 2'b00) begin
      miscompares++; $display("FAIL rst_no_resp: got %b want 00", b0.req_resp);
    end
    // fresh request after release
    b0.req_read[1] = 1'b1;
    b0.req_addr[32 +: 32] = 32'h0000_1100;
    tick();
    vectors++;
    if ({b0.mem_read, b0.grant_idx, b0.mem_addr} !== {1'b1, 1'b1, 32'h0000_1100}) begin
      miscompares++; $display("FAIL rst_regrant: got rd=%0b idx=%0d addr=%h want 1/1/00001100", b0.mem_read, b0.grant_idx, b0.mem_addr);
    end
    b0.mem_resp = 1'b1;
    tick();
    b0.mem_resp = 1'b0;
    vectors++;
    if (b0.req_resp !== 2'b10) begin
      miscompares++; $display("FAIL rst_regrant_resp: got %b want 10", b0.req_resp);
    end
    b0.req_read = '0;
    tick();
  endtask

  task automatic test_single_read();
    b0.req_read[1] = 1'b1;
    b0.req_addr[32 +: 32] = 32'h0000_2040;
    tick();
    vectors++;
    if ({b0.mem_read, b0.mem_write, b0.mem_addr, b0.grant_idx, b0.grant_valid}
        !== {1'b1, 1'b0, 32'h0000_2040, 1'b1, 1'b1}) begin
      miscompares++; $display("FAIL rd_issue: got rd=%0b wr=%0b addr=%h idx=%0d gv=%0b want 1/0/00002040/1/1",
                              b0.mem_read, b0.mem_write, b0.mem_addr, b0.grant_idx, b0.grant_valid);
    end
    vectors++;
    if (b0.mem_wdata !== 256'd0) begin
      miscompares++; $display("FAIL rd_wdata_zero: got %h want 0", b0.mem_wdata);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if ({b0.mem_read, b0.req_resp} !== 3'b100) begin
        miscompares++; $display("FAIL rd_wait%0d: got rd=%0b resp=%b want 1/00", i, b0.mem_read, b0.req_resp);
      end
    end
    b0.mem_resp = 1'b1;
    b0.mem_rdata = {8{32'hDEADBEEF}};
    tick();
    b0.mem_resp = 1'b0;
    b0.mem_rdata = '0;
    vectors++;
    if ({b0.req_resp, b0.mem_read} !== 3'b100) begin
      miscompares++; $display("FAIL rd_resp: got resp=%b rd=%0b want 10/0", b0.req_resp, b0.mem_read);
    end
    vectors++;
    if (b0.req_rdata !== {8{32'hDEADBEEF}}) begin
      miscompares++; $display("FAIL rd_rdata: got %h want DEADBEEF x8", b0.req_rdata);
    end
    b0.req_read = '0;
    tick();
    vectors++;
    if ({b0.req_resp, b0.grant_valid} !== 3'b000) begin
      miscompares++; $display("FAIL rd_after: got resp=%b gv=%0b want 00/0", b0.req_resp, b0.grant_valid);
    end
  endtask

  task automatic test_single_write();
    b0.req_write[0] = 1'b1;
    b0.req_addr[0 +: 32] = 32'h0000_3000;
    b0.req_wdata[0 +: 256] = {8{32'hA5A5A5A5}};
    tick();
    vectors++;
    if ({b0.mem_write, b0.mem_read, b0.mem_addr, b0.grant_idx} !== {1'b1, 1'b0, 32'h0000_3000, 1'b0}) begin
      miscompares++; $display("FAIL wr_issue: got wr=%0b rd=%0b addr=%h idx=%0d want 1/0/00003000/0",
                              b0.mem_write, b0.mem_read, b0.mem_addr, b0.grant_idx);
    end
    vectors++;
    if (b0.mem_wdata !== {8{32'hA5A5A5A5}}) begin
      miscompares++; $display("FAIL wr_wdata: got %h want A5A5A5A5 x8", b0.mem_wdata);
    end
    tick();
    b0.mem_resp = 1'b1;
    tick();
    b0.mem_resp = 1'b0;
    vectors++;
    if ({b0.req_resp, b0.mem_write} !== 3'b010) begin
      miscompares++; $display("FAIL wr_resp: got resp=%b wr=%0b want 01/0", b0.req_resp, b0.mem_write);
    end
    b0.req_write = '0;
    b0.req_wdata = '0;
    tick();
    vectors++;
    if (b0.req_resp !== 2'b00) begin
      miscompares++; $display("FAIL wr_resp_one_cycle: got %b want 00", b0.req_resp);
    end
  endtask

  task automatic test_fixed_collision();
    logic ok; int idx; logic [1:0] resp;
    b0.req_read = 2'b11;
    b0.req_addr = {32'h0000_0200, 32'h0000_0100};
    serve_d0(1, ok, idx, resp);
    vectors++;
    if ({ok, resp} !== 3'b101 || idx != 0) begin
      miscompares++; $display("FAIL fix_first: got ok=%0b idx=%0d resp=%b want 1/0/01", ok, idx, resp);
    end
    b0.req_read[0] = 1'b0;
    tick();
    vectors++;
    if ({b0.mem_read, b0.mem_write, b0.grant_valid} !== 3'b000) begin
      miscompares++; $display("FAIL fix_gap: got rd=%0b wr=%0b gv=%0b want 000", b0.mem_read, b0.mem_write, b0.grant_valid);
    end
    serve_d0(2, ok, idx, resp);
    vectors++;
    if ({ok, resp} !== 3'b110 || idx != 1) begin
      miscompares++; $display("FAIL fix_second: got ok=%0b idx=%0d resp=%b want 1/1/10", ok, idx, resp);
    end
    b0.req_read = '0;
    tick();
    // port 0 keeps requesting; port 1 must wait
    b0.req_read = 2'b11;
    for (int i = 0; i < 3; i++) begin
      serve_d0(0, ok, idx, resp);
      vectors++;
      if ({ok, resp} !== 3'b101 || idx != 0) begin
        miscompares++; $display("FAIL fix_starve%0d: got ok=%0b idx=%0d resp=%b want 1/0/01", i, ok, idx, resp);
      end
    end
    b0.req_read[0] = 1'b0;
    serve_d0(0, ok, idx, resp);
    vectors++;
    if ({ok, resp} !== 3'b110 || idx != 1) begin
      miscompares++; $display("FAIL fix_release: got ok=%0b idx=%0d resp=%b want 1/1/10", ok, idx, resp);
    end
    b0.req_read = '0;
    tick();
  endtask

  task automatic test_round_robin();
    logic ok; int idx; logic [3:0] resp; logic [3:0] exp_r;
    int order [8] = '{0, 1, 2, 3, 0, 1, 3, 1};
    b1.req_read = 4'b1111;
    b1.req_addr = {32'h0000_0D00, 32'h0000_0C00, 32'h0000_0B00, 32'h0000_0A00};
    for (int i = 0; i < 8; i++) begin
      serve_d1(1, ok, idx, resp);
      exp_r = 4'b0001 << order[i];
      vectors++;
      if (ok !== 1'b1 || idx != order[i] || resp !== exp_r) begin
        miscompares++; $display("FAIL rr_grant%0d: got ok=%0b idx=%0d resp=%b want idx=%0d resp=%b",
                                i, ok, idx, resp, order[i], exp_r);
      end
      if (i == 4) b1.req_read = 4'b1010;
    end
    b1.req_read = '0;
    tick(); tick();
    vectors++;
    if ({b1.grant_valid, b1.mem_read} !== 2'b00) begin
      miscompares++; $display("FAIL rr_idle: got gv=%0b rd=%0b want 00", b1.grant_valid, b1.mem_read);
    end
  endtask

  task automatic test_corners();
    // read and write together: write first, read afterwards
    b0.req_read[0] = 1'b1;
    b0.req_write[0] = 1'b1;
    b0.req_addr[0 +: 32] = 32'h0000_3300;
    b0.req_wdata[0 +: 256] = {8{32'h1234_5678}};
    tick();
    vectors++;
    if ({b0.mem_read, b0.mem_write} !== 2'b01) begin
      miscompares++; $display("FAIL rw_write_first: got rd=%0b wr=%0b want 0/1", b0.mem_read, b0.mem_write);
    end
    b0.mem_resp = 1'b1;
    tick();
    b0.mem_resp = 1'b0;
    b0.req_write[0] = 1'b0;
    tick(); tick();
    vectors++;
    if ({b0.mem_read, b0.mem_write, b0.grant_idx, b0.mem_wdata} !== {1'b1, 1'b0, 1'b0, 256'd0}) begin
      miscompares++; $display("FAIL rw_read_later: got rd=%0b wr=%0b idx=%0d want 1/0/0 wdata 0", b0.mem_read, b0.mem_write, b0.grant_idx);
    end
    b0.mem_resp = 1'b1;
    tick();
    b0.mem_resp = 1'b0;
    b0.req_read = '0;
    tick();
    // granted port changes its inputs while busy
    b0.req_read[1] = 1'b1;
    b0.req_addr[32 +: 32] = 32'h0000_4000;
    tick();
    b0.req_addr[32 +: 32] = 32'h0000_5000;
    b0.req_write[1] = 1'b1;
    tick();
    vectors++;
    if ({b0.mem_addr, b0.mem_read, b0.mem_write} !== {32'h0000_4000, 1'b1, 1'b0}) begin
      miscompares++; $display("FAIL busy_latched: got addr=%h rd=%0b wr=%0b want 00004000/1/0", b0.mem_addr, b0.mem_read, b0.mem_write);
    end
    b0.mem_resp = 1'b1;
    tick();
    b0.mem_resp = 1'b0;
    vectors++;
    if (b0.req_resp !== 2'b10) begin
      miscompares++; $display("FAIL busy_resp: got %b want 10", b0.req_resp);
    end
    b0.req_read = '0;
    b0.req_write = '0;
    tick();
    // stray memory response while idle
    b0.mem_resp = 1'b1;
    tick();
    b0.mem_resp = 1'b0;
    tick();
    vectors++;
    if ({b0.req_resp, b0.grant_valid, b0.mem_read} !== 4'b0000) begin
      miscompares++; $display("FAIL idle_resp_ignored: got resp=%b gv=%0b rd=%0b want 00/0/0", b0.req_resp, b0.grant_valid, b0.mem_read);
    end
    // zero-wait memory
    b0.req_read[0] = 1'b1;
    b0.req_addr[0 +: 32] = 32'h0000_6000;
    tick();
    b0.mem_resp = 1'b1;
    b0.mem_rdata = {8{32'h0BAD_F00D}};
    tick();
    b0.mem_resp = 1'b0;
    b0.mem_rdata = '0;
    vectors++;
    if ({b0.req_resp, b0.req_rdata} !== {2'b01, {8{32'h0BAD_F00D}}}) begin
      miscompares++; $display("FAIL zero_wait: got resp=%b rdata=%h want 01 0BADF00D x8", b0.req_resp, b0.req_rdata[31:0]);
    end
    b0.req_read = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_fixed_collision();
    test_round_robin();
    test_corners();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
